// File: rtl/rf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_pkg : shared register-file widths and write-back request types |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rf_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_WIDTH = 32;
    localparam int ADR_WIDTH = 5;

    typedef logic [ADR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        reg_data_t data;
    } wb_req_t;

    localparam reg_addr_t RF_ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant, pointer on accept    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_cand;
    logic             w_found;
    int               w_sum;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_sum     = 0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_cand = PTR_W'(w_sum);
            if (!w_found && req[w_cand]) begin
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
                w_found       = 1'b1;
            end
        end
    end

    // Every grant is an accepted transfer, since grant is only given to a valid requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|grant) begin
            r_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_wb_scheduler : write-port arbitration + pending scoreboard |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module regfile_wb_scheduler
    import rf_pkg::*;
#(
    parameter int                 NUM_SRC   = 2,
    parameter logic [NUM_SRC-1:0] LONG_MASK = NUM_SRC'(2'b10)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*ADR_WIDTH-1:0] src_rd,
    input  logic [NUM_SRC*REG_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         rf_we,
    output logic [ADR_WIDTH-1:0]         rf_ad,
    output logic [REG_WIDTH-1:0]         rf_wd,
    input  logic                         iss_valid,
    input  logic                         iss_long,
    input  logic [ADR_WIDTH-1:0]         iss_rd,
    input  logic [ADR_WIDTH-1:0]         iss_rs1,
    input  logic [ADR_WIDTH-1:0]         iss_rs2,
    output logic                         iss_stall,
    output logic [REG_COUNT-1:0]         pending,
    output logic [ADR_WIDTH:0]           pending_cnt
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_req_t              w_reqs [NUM_SRC];
    logic [NUM_SRC-1:0]   w_req_valid;
    logic [NUM_SRC-1:0]   w_grant;
    logic [SEL_W-1:0]     w_grant_idx;
    wb_req_t              w_sel;
    logic                 w_xfer;
    logic                 w_sel_long;
    logic                 r_wb_long;
    logic                 w_issue_set;
    logic [REG_COUNT-1:0] w_set_vec;
    logic [REG_COUNT-1:0] w_clr_vec;
    logic [REG_COUNT-1:0] w_pending_nxt;

    function automatic logic pend_bit(input logic [REG_COUNT-1:0] vec, input reg_addr_t r);
        return vec[r] && (r != RF_ZERO_REG);
    endfunction

    function automatic logic [ADR_WIDTH:0] popcount(input logic [REG_COUNT-1:0] vec);
        logic [ADR_WIDTH:0] cnt;
        cnt = '0;
        for (int k = 0; k < REG_COUNT; k++) begin
            cnt = cnt + (ADR_WIDTH + 1)'(vec[k]);
        end
        return cnt;
    endfunction

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign w_reqs[i].valid = src_valid[i];
            assign w_reqs[i].rd    = src_rd[i*ADR_WIDTH +: ADR_WIDTH];
            assign w_reqs[i].data  = src_data[i*REG_WIDTH +: REG_WIDTH];
            assign w_req_valid[i]  = w_reqs[i].valid;
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_SRC)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_req_valid),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign src_ready  = w_grant;
    assign w_xfer     = |w_grant;
    assign w_sel      = w_reqs[w_grant_idx];
    assign w_sel_long = LONG_MASK[w_grant_idx];

    // Writes to x0 are accepted from the source but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_ad     <= '0;
            rf_wd     <= '0;
            r_wb_long <= 1'b0;
        end else begin
            rf_we     <= w_xfer && (w_sel.rd != RF_ZERO_REG);
            r_wb_long <= w_xfer && (w_sel.rd != RF_ZERO_REG) && w_sel_long;
            if (w_xfer) begin
                rf_ad <= w_sel.rd;
                rf_wd <= w_sel.data;
            end
        end
    end

    assign iss_stall = iss_valid && (pend_bit(pending, iss_rs1) ||
                                     pend_bit(pending, iss_rs2) ||
                                     (iss_long && pend_bit(pending, iss_rd)));

    assign w_issue_set = iss_valid && !iss_stall && iss_long && (iss_rd != RF_ZERO_REG);

    // Set is applied after clear so a same-edge set of the same register wins.
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (w_issue_set) begin
            w_set_vec[iss_rd] = 1'b1;
        end
        if (rf_we && r_wb_long) begin
            w_clr_vec[rf_ad] = 1'b1;
        end
        w_pending_nxt = (pending & ~w_clr_vec) | w_set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= w_pending_nxt;
            pending_cnt <= popcount(w_pending_nxt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_wb_scheduler : directed self-checking bench             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic [1:0]  src_valid;
    logic [9:0]  src_rd;
    logic [63:0] src_data;
    logic [1:0]  src_ready;
    logic        rf_we;
    logic [4:0]  rf_ad;
    logic [31:0] rf_wd;
    logic        iss_valid;
    logic        iss_long;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        iss_stall;
    logic [31:0] pending;
    logic [5:0]  pending_cnt;

    int total = 0;
    int bad   = 0;

    regfile_wb_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_rd      (src_rd),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .rf_we       (rf_we),
        .rf_ad       (rf_ad),
        .rf_wd       (rf_wd),
        .iss_valid   (iss_valid),
        .iss_long    (iss_long),
        .iss_rd      (iss_rd),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_stall   (iss_stall),
        .pending     (pending),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
        iss_valid = 1'b0;
        iss_long  = 1'b0;
        iss_rd    = '0;
        iss_rs1   = '0;
        iss_rs2   = '0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [1:0] exp_rdy [4];
        logic [4:0] exp_ad  [4];
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_ad  = '{5'd3, 5'd4, 5'd3, 5'd4};

        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_we",     32'(rf_we), 0);
        chk("rst_ad",     32'(rf_ad), 0);
        chk("rst_wd",     rf_wd, 0);
        chk("rst_pend",   pending, 0);
        chk("rst_cnt",    32'(pending_cnt), 0);
        chk("rst_stall",  32'(iss_stall), 0);
        chk("rst_ready",  32'(src_ready), 0);

        // Single write from source 0
        src_valid = 2'b01;
        src_rd[4:0] = 5'd5;
        src_data[31:0] = 32'h0000_1234;
        #1;
        chk("single_ready", 32'(src_ready), 32'h1);
        step();
        src_valid = '0;
        chk("single_we", 32'(rf_we), 1);
        chk("single_ad", 32'(rf_ad), 5);
        chk("single_wd", rf_wd, 32'h1234);
        step();
        chk("single_we_off", 32'(rf_we), 0);
        chk("single_ad_hold", 32'(rf_ad), 5);

        // Round-robin from a fresh pointer
        do_reset();
        src_valid = 2'b11;
        src_rd    = {5'd4, 5'd3};
        src_data  = {32'hBBBB_0004, 32'hAAAA_0003};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 32'(src_ready), 32'(exp_rdy[k]));
            step();
            chk("rr_we", 32'(rf_we), 1);
            chk("rr_ad", 32'(rf_ad), 32'(exp_ad[k]));
        end
        chk("rr_wd", rf_wd, 32'hBBBB_0004);
        idle_inputs();
        step();

        // Long-latency destination sets scoreboard, RAW stall, clear on write
        iss_valid = 1'b1;
        iss_long  = 1'b1;
        iss_rd    = 5'd7;
        #1;
        chk("sb_issue_nostall", 32'(iss_stall), 0);
        step();
        chk("sb_pend_set", pending, 32'h0000_0080);
        chk("sb_cnt_one", 32'(pending_cnt), 1);
        iss_long = 1'b0;
        iss_rd   = 5'd0;
        iss_rs1  = 5'd7;
        #1;
        chk("sb_raw_stall", 32'(iss_stall), 1);
        src_valid = 2'b10;
        src_rd    = {5'd7, 5'd0};
        src_data  = {32'h0000_0077, 32'h0};
        #1;
        chk("sb_src1_ready", 32'(src_ready), 32'h2);
        step();
        src_valid = '0;
        chk("sb_wb_we", 32'(rf_we), 1);
        chk("sb_wb_ad", 32'(rf_ad), 7);
        chk("sb_stall_wbcyc", 32'(iss_stall), 1);
        step();
        chk("sb_stall_after", 32'(iss_stall), 0);
        chk("sb_pend_clr", pending, 0);
        chk("sb_cnt_zero", 32'(pending_cnt), 0);
        idle_inputs();

        // x0 never written and never tracked
        src_valid = 2'b10;
        src_rd    = {5'd0, 5'd0};
        src_data  = {32'hDEAD_BEEF, 32'h0};
        iss_valid = 1'b1;
        iss_long  = 1'b1;
        iss_rd    = 5'd0;
        #1;
        chk("x0_ready", 32'(src_ready), 32'h2);
        chk("x0_stall", 32'(iss_stall), 0);
        step();
        idle_inputs();
        chk("x0_we", 32'(rf_we), 0);
        chk("x0_pend", pending, 0);

        // Non-long source write leaves scoreboard bit alone
        iss_valid = 1'b1;
        iss_long  = 1'b1;
        iss_rd    = 5'd9;
        step();
        idle_inputs();
        chk("nl_pend_set", pending, 32'h0000_0200);
        src_valid = 2'b01;
        src_rd    = {5'd0, 5'd9};
        src_data  = {32'h0, 32'h0000_0099};
        step();
        src_valid = '0;
        chk("nl_we", 32'(rf_we), 1);
        chk("nl_ad", 32'(rf_ad), 9);
        step();
        chk("nl_pend_kept", pending, 32'h0000_0200);
        chk("nl_cnt_kept", 32'(pending_cnt), 1);

        // Asynchronous reset with writes and scoreboard state live
        do_reset();
        iss_valid = 1'b1;
        iss_long  = 1'b1;
        iss_rd    = 5'd7;
        step();
        iss_rd    = 5'd8;
        step();
        idle_inputs();
        chk("ar_pend", pending, 32'h0000_0180);
        chk("ar_cnt", 32'(pending_cnt), 2);
        src_valid = 2'b01;
        src_rd    = {5'd0, 5'd12};
        src_data  = {32'h0, 32'hCAFE_F00D};
        step();
        src_valid = '0;
        chk("ar_we_inflight", 32'(rf_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we_clr", 32'(rf_we), 0);
        chk("ar_ad_clr", 32'(rf_ad), 0);
        chk("ar_wd_clr", rf_wd, 0);
        chk("ar_pend_clr", pending, 0);
        chk("ar_cnt_clr", 32'(pending_cnt), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("ar_no_write", 32'(rf_we), 0);
        chk("ar_pend_stay", pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
